// File: rtl/io_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : io_port_arbiter
// Brief    : Two-master round-robin sequencer driving the IOPorts access lines
// Revision : 1.0 - initial release
// ============================================================================
module io_port_arbiter #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int WAIT_CYCLES = 1,
  parameter int CNT_W       = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  // master 0: CPU load/store path
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_busy,
  output logic              m0_ack,
  output logic              m0_err,
  output logic [DATA_W-1:0] m0_rdata,
  // master 1: debug / DMA requester
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_busy,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [DATA_W-1:0] m1_rdata,
  // IOPorts side
  output logic [ADDR_W-1:0] io_access_addr,
  output logic [DATA_W-1:0] io_in,
  output logic              io_write_en,
  output logic              io_read_en,
  input  logic [DATA_W-1:0] io_out
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_gnt;
  logic              r_last_grant;
  logic              r_err;

  logic [1:0]        r_pend;
  logic [1:0]        r_pend_q;
  logic [1:0]        r_we;
  logic [ADDR_W-1:0] r_addr  [2];
  logic [DATA_W-1:0] r_wdata [2];
  logic [DATA_W-1:0] r_rdata [2];

  // --------------------------------------------------------------------------
  // Combinational decode
  // --------------------------------------------------------------------------
  logic [1:0]        w_req;
  logic [1:0]        w_we_in;
  logic [ADDR_W-1:0] w_addr_in  [2];
  logic [DATA_W-1:0] w_wdata_in [2];
  logic [1:0]        w_in_svc;
  logic [1:0]        w_busy;
  logic [1:0]        w_cap;
  logic [1:0]        w_ready;
  logic [1:0]        w_ack;
  logic              w_sel;
  logic              w_grant;
  logic              w_access;
  logic              w_last_beat;

  assign w_req         = {m1_req, m0_req};
  assign w_we_in       = {m1_we, m0_we};
  assign w_addr_in[0]  = m0_addr;
  assign w_addr_in[1]  = m1_addr;
  assign w_wdata_in[0] = m0_wdata;
  assign w_wdata_in[1] = m1_wdata;

  assign w_in_svc = (r_state != S_IDLE) ? {r_gnt, ~r_gnt} : 2'b00;
  assign w_busy   = r_pend | w_in_svc;
  // A strobe from a busy master is dropped without touching any state.
  assign w_cap    = w_req & ~w_busy;

  // A pend bit only becomes eligible one cycle after it was captured.
  assign w_ready  = r_pend & r_pend_q;
  assign w_sel    = (&w_ready) ? ~r_last_grant : w_ready[1];
  assign w_grant  = (r_state == S_IDLE) && (|w_ready);

  assign w_access    = (r_state == S_ACCESS);
  assign w_last_beat = w_access && (r_cnt == '0);

  // --------------------------------------------------------------------------
  // Request capture per master
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pend   <= '0;
      r_pend_q <= '0;
      r_we     <= '0;
      for (int i = 0; i < 2; i++) begin
        r_addr[i]  <= '0;
        r_wdata[i] <= '0;
      end
    end else begin
      r_pend_q <= r_pend;
      for (int i = 0; i < 2; i++) begin
        if (w_cap[i]) begin
          r_pend[i]  <= 1'b1;
          r_we[i]    <= w_we_in[i];
          r_addr[i]  <= w_addr_in[i];
          r_wdata[i] <= w_wdata_in[i];
        end else if (w_grant && (w_sel == 1'(i))) begin
          r_pend[i]  <= 1'b0;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_gnt        <= 1'b0;
      r_last_grant <= 1'b1;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_gnt        <= w_sel;
            r_last_grant <= w_sel;
            // The wait counter is loaded only here, so it can never wrap.
            if (r_addr[w_sel][ADDR_W-1]) begin
              r_state <= S_ACCESS;
              r_cnt   <= C_CNT_LOAD;
              r_err   <= 1'b0;
            end else begin
              r_state <= S_RESP;
              r_err   <= 1'b1;
            end
          end
        end
        S_ACCESS: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Read data is sampled on the edge that ends the final ACCESS cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_rdata[i] <= '0;
      end
    end else if (w_last_beat && !r_we[r_gnt]) begin
      r_rdata[r_gnt] <= io_out;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign io_access_addr = w_access ? r_addr[r_gnt]  : '0;
  assign io_in          = w_access ? r_wdata[r_gnt] : '0;
  assign io_write_en    = w_access &  r_we[r_gnt];
  assign io_read_en     = w_access & ~r_we[r_gnt];

  assign w_ack    = (r_state == S_RESP) ? w_in_svc : 2'b00;

  assign m0_busy  = w_busy[0];
  assign m1_busy  = w_busy[1];
  assign m0_ack   = w_ack[0];
  assign m1_ack   = w_ack[1];
  assign m0_err   = w_ack[0] & r_err;
  assign m1_err   = w_ack[1] & r_err;
  assign m0_rdata = r_rdata[0];
  assign m1_rdata = r_rdata[1];

endmodule
`default_nettype wire

// File: tb/tb_io_port_arbiter.sv
`default_nettype none
// Bench for io_port_arbiter: instances with WAIT_CYCLES 1 and 3 share the same
// stimulus; each is checked against a transaction-level latency/ordering model.
module tb_io_port_arbiter;

  localparam int DW = 16;
  localparam int AW = 16;

  logic          clk;
  logic          rst_n;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata, io_out;

  logic [1:0]          busy0_v, busy1_v, ack0_v, ack1_v, err0_v, err1_v, wen_v, ren_v;
  logic [1:0][DW-1:0]  rdata0_v, rdata1_v, ioin_v;
  logic [1:0][AW-1:0]  ioaddr_v;

  io_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(1), .CNT_W(4)) u_dut_w1 (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_busy(busy0_v[0]), .m0_ack(ack0_v[0]), .m0_err(err0_v[0]), .m0_rdata(rdata0_v[0]),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_busy(busy1_v[0]), .m1_ack(ack1_v[0]), .m1_err(err1_v[0]), .m1_rdata(rdata1_v[0]),
    .io_access_addr(ioaddr_v[0]), .io_in(ioin_v[0]),
    .io_write_en(wen_v[0]), .io_read_en(ren_v[0]), .io_out(io_out)
  );

  io_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(3), .CNT_W(4)) u_dut_w3 (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_busy(busy0_v[1]), .m0_ack(ack0_v[1]), .m0_err(err0_v[1]), .m0_rdata(rdata0_v[1]),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_busy(busy1_v[1]), .m1_ack(ack1_v[1]), .m1_err(err1_v[1]), .m1_rdata(rdata1_v[1]),
    .io_access_addr(ioaddr_v[1]), .io_in(ioin_v[1]),
    .io_write_en(wen_v[1]), .io_read_en(ren_v[1]), .io_out(io_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // observations gathered per instance [i] and master [m]
  int            ack_cnt   [2][2];
  int            ack_cyc   [2][2];
  logic          ack_err   [2][2];
  logic [DW-1:0] ack_rdata [2][2];
  int            wr_cnt [2], rd_cnt [2], en_bad [2], idle_bad [2];
  logic          en_seen [2];
  logic [AW-1:0] first_en_addr [2];
  logic          chk_en;
  logic [AW-1:0] exp_en_addr;
  logic [DW-1:0] exp_en_wdata;

  // reference model state
  logic [DW-1:0] exp_rd [2][2];
  int            mlast  [2];

  function automatic int wc(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic clear_obs();
    for (int i = 0; i < 2; i++) begin
      for (int m = 0; m < 2; m++) begin
        ack_cnt[i][m] = 0; ack_cyc[i][m] = -1; ack_err[i][m] = 1'b0; ack_rdata[i][m] = '0;
      end
      wr_cnt[i] = 0; rd_cnt[i] = 0; en_bad[i] = 0; idle_bad[i] = 0;
      en_seen[i] = 1'b0; first_en_addr[i] = '0;
    end
    chk_en = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (wen_v[i] || ren_v[i]) begin
        if (wen_v[i]) wr_cnt[i]++;
        if (ren_v[i]) rd_cnt[i]++;
        if (wen_v[i] && ren_v[i]) en_bad[i]++;
        if (!en_seen[i]) begin
          en_seen[i] = 1'b1;
          first_en_addr[i] = ioaddr_v[i];
        end
        if (chk_en && (ioaddr_v[i] !== exp_en_addr || (wen_v[i] && ioin_v[i] !== exp_en_wdata)))
          en_bad[i]++;
      end else if (ioaddr_v[i] !== '0 || ioin_v[i] !== '0) begin
        idle_bad[i]++;
      end
      if ((err0_v[i] && !ack0_v[i]) || (err1_v[i] && !ack1_v[i])) idle_bad[i]++;
      if (ack0_v[i]) begin
        if (ack_cnt[i][0] == 0) begin
          ack_cyc[i][0] = cyc; ack_err[i][0] = err0_v[i]; ack_rdata[i][0] = rdata0_v[i];
        end
        ack_cnt[i][0]++;
      end
      if (ack1_v[i]) begin
        if (ack_cnt[i][1] == 0) begin
          ack_cyc[i][1] = cyc; ack_err[i][1] = err1_v[i]; ack_rdata[i][1] = rdata1_v[i];
        end
        ack_cnt[i][1]++;
      end
    end
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
    repeat (n) step();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_rd[i][0] = '0; exp_rd[i][1] = '0; mlast[i] = 1;
    end
  endtask

  task automatic test_reset();
    logic [71:0] snap;
    m0_we = 0; m1_we = 0; m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0; io_out = '0;
    do_reset(3);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 2; i++) begin
        snap = {busy0_v[i], busy1_v[i], ack0_v[i], ack1_v[i], err0_v[i], err1_v[i], wen_v[i],
                ren_v[i], ioaddr_v[i], ioin_v[i], rdata0_v[i], rdata1_v[i]};
        n_tests++;
        if (snap !== '0) begin
          n_fail++;
          $display("FAIL reset_outputs inst%0d phase%0d: got %h expected 0", i, k, snap);
        end
      end
      if (k == 0) step();
    end
  endtask

  task automatic test_read();
    int t0;
    clear_obs();
    io_out = 16'h1234; chk_en = 1'b1; exp_en_addr = 16'h8004; exp_en_wdata = '0;
    m0_we = 1'b0; m0_addr = 16'h8004; m0_wdata = '0; m0_req = 1'b1;
    step(); t0 = cyc; m0_req = 1'b0;
    repeat (10) step();
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (rd_cnt[i] != wc(i) || wr_cnt[i] != 0) begin
        n_fail++; $display("FAIL read_enables inst%0d: got rd=%0d wr=%0d expected rd=%0d wr=0", i, rd_cnt[i], wr_cnt[i], wc(i));
      end
      n_tests++;
      if (ack_cnt[i][0] != 1 || ack_cyc[i][0] != t0 + wc(i) + 2) begin
        n_fail++; $display("FAIL read_ack inst%0d: got cnt=%0d at %0d expected 1 at %0d", i, ack_cnt[i][0], ack_cyc[i][0] - t0, wc(i) + 2);
      end
      n_tests++;
      if (ack_rdata[i][0] !== 16'h1234 || ack_err[i][0] !== 1'b0) begin
        n_fail++; $display("FAIL read_data inst%0d: got %h err=%b expected 1234 err=0", i, ack_rdata[i][0], ack_err[i][0]);
      end
      n_tests++;
      if (en_bad[i] != 0 || idle_bad[i] != 0 || ack_cnt[i][1] != 0) begin
        n_fail++; $display("FAIL read_bus inst%0d: got bad=%0d idle=%0d m1ack=%0d expected 0", i, en_bad[i], idle_bad[i], ack_cnt[i][1]);
      end
      exp_rd[i][0] = 16'h1234; mlast[i] = 0;
    end
  endtask

  task automatic test_write();
    int t0;
    clear_obs();
    io_out = 16'($urandom); chk_en = 1'b1; exp_en_addr = 16'h8010; exp_en_wdata = 16'hBEEF;
    m1_we = 1'b1; m1_addr = 16'h8010; m1_wdata = 16'hBEEF; m1_req = 1'b1;
    step(); t0 = cyc; m1_req = 1'b0;
    repeat (10) step();
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (wr_cnt[i] != wc(i) || rd_cnt[i] != 0 || en_bad[i] != 0) begin
        n_fail++; $display("FAIL write_enables inst%0d: got wr=%0d rd=%0d bad=%0d expected wr=%0d", i, wr_cnt[i], rd_cnt[i], en_bad[i], wc(i));
      end
      n_tests++;
      if (ack_cnt[i][1] != 1 || ack_cyc[i][1] != t0 + wc(i) + 2 || ack_err[i][1] !== 1'b0) begin
        n_fail++; $display("FAIL write_ack inst%0d: got cnt=%0d at %0d err=%b expected 1 at %0d", i, ack_cnt[i][1], ack_cyc[i][1] - t0, ack_err[i][1], wc(i) + 2);
      end
      n_tests++;
      if (ack_rdata[i][1] !== exp_rd[i][1] || ack_cnt[i][0] != 0 || idle_bad[i] != 0) begin
        n_fail++; $display("FAIL write_side inst%0d: got rdata=%h m0ack=%0d idle=%0d expected %h 0 0", i, ack_rdata[i][1], ack_cnt[i][0], idle_bad[i], exp_rd[i][1]);
      end
      mlast[i] = 1;
    end
  endtask

  task automatic test_err();
    int t0;
    clear_obs();
    io_out = 16'($urandom);
    m0_we = 1'b0; m0_addr = 16'h0004; m0_req = 1'b1;
    step(); t0 = cyc; m0_req = 1'b0;
    repeat (8) step();
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (wr_cnt[i] + rd_cnt[i] != 0) begin
        n_fail++; $display("FAIL err_enables inst%0d: got %0d enable cycles expected 0", i, wr_cnt[i] + rd_cnt[i]);
      end
      n_tests++;
      if (ack_cnt[i][0] != 1 || ack_cyc[i][0] != t0 + 2 || ack_err[i][0] !== 1'b1) begin
        n_fail++; $display("FAIL err_ack inst%0d: got cnt=%0d at %0d err=%b expected 1 at 2 err=1", i, ack_cnt[i][0], ack_cyc[i][0] - t0, ack_err[i][0]);
      end
      n_tests++;
      if (ack_rdata[i][0] !== exp_rd[i][0]) begin
        n_fail++; $display("FAIL err_rdata inst%0d: got %h expected %h", i, ack_rdata[i][0], exp_rd[i][0]);
      end
      mlast[i] = 0;
    end
  endtask

  task automatic test_random();
    int t0, m, lat, ewr, erd;
    logic we, msb;
    logic [AW-1:0] ad;
    logic [DW-1:0] wd;
    for (int k = 0; k < 8; k++) begin
      clear_obs();
      m   = int'($urandom_range(0, 1));
      we  = 1'($urandom);
      msb = ($urandom_range(0, 3) != 0);
      ad  = 16'($urandom); ad[AW-1] = msb;
      wd  = 16'($urandom);
      io_out = 16'($urandom);
      chk_en = 1'b1; exp_en_addr = ad; exp_en_wdata = wd;
      if (m == 0) begin m0_we = we; m0_addr = ad; m0_wdata = wd; m0_req = 1'b1; end
      else        begin m1_we = we; m1_addr = ad; m1_wdata = wd; m1_req = 1'b1; end
      step(); t0 = cyc; m0_req = 1'b0; m1_req = 1'b0;
      repeat (10) step();
      for (int i = 0; i < 2; i++) begin
        lat = msb ? wc(i) + 2 : 2;
        ewr = (msb && we)  ? wc(i) : 0;
        erd = (msb && !we) ? wc(i) : 0;
        if (msb && !we) exp_rd[i][m] = io_out;
        n_tests++;
        if (wr_cnt[i] != ewr || rd_cnt[i] != erd || en_bad[i] != 0 || idle_bad[i] != 0) begin
          n_fail++; $display("FAIL rand_bus inst%0d k%0d: got wr=%0d rd=%0d bad=%0d idle=%0d expected wr=%0d rd=%0d", i, k, wr_cnt[i], rd_cnt[i], en_bad[i], idle_bad[i], ewr, erd);
        end
        n_tests++;
        if (ack_cnt[i][m] != 1 || ack_cyc[i][m] != t0 + lat || ack_err[i][m] !== !msb || ack_cnt[i][1-m] != 0) begin
          n_fail++; $display("FAIL rand_ack inst%0d k%0d m%0d: got cnt=%0d at %0d err=%b expected 1 at %0d err=%b", i, k, m, ack_cnt[i][m], ack_cyc[i][m] - t0, ack_err[i][m], lat, !msb);
        end
        n_tests++;
        if (ack_rdata[i][m] !== exp_rd[i][m]) begin
          n_fail++; $display("FAIL rand_rdata inst%0d k%0d: got %h expected %h", i, k, ack_rdata[i][m], exp_rd[i][m]);
        end
        mlast[i] = m;
      end
    end
  endtask

  task automatic test_contention();
    int masks [4] = '{3, 1, 3, 3};
    int t0, mask, f, s;
    logic [AW-1:0] ad [2];
    logic          wev [2];
    do_reset(2);
    step();
    for (int r = 0; r < 4; r++) begin
      clear_obs();
      mask = masks[r];
      io_out = 16'($urandom);
      for (int m = 0; m < 2; m++) begin
        ad[m] = 16'($urandom); ad[m][AW-1] = 1'b1; wev[m] = 1'($urandom);
      end
      m0_we = wev[0]; m0_addr = ad[0]; m0_wdata = 16'($urandom); m0_req = mask[0];
      m1_we = wev[1]; m1_addr = ad[1]; m1_wdata = 16'($urandom); m1_req = mask[1];
      step(); t0 = cyc; m0_req = 1'b0; m1_req = 1'b0;
      repeat (14) step();
      for (int i = 0; i < 2; i++) begin
        if (mask == 3) begin f = (mlast[i] == 1) ? 0 : 1; s = 1 - f; end
        else           begin f = (mask == 1) ? 0 : 1;     s = -1;    end
        if (!wev[f]) exp_rd[i][f] = io_out;
        n_tests++;
        if (ack_cnt[i][f] != 1 || ack_cyc[i][f] != t0 + wc(i) + 2 || first_en_addr[i] !== ad[f]) begin
          n_fail++; $display("FAIL rr_first inst%0d r%0d m%0d: got cnt=%0d at %0d addr=%h expected 1 at %0d addr=%h", i, r, f, ack_cnt[i][f], ack_cyc[i][f] - t0, first_en_addr[i], wc(i) + 2, ad[f]);
        end
        n_tests++;
        if (ack_rdata[i][f] !== exp_rd[i][f]) begin
          n_fail++; $display("FAIL rr_first_data inst%0d r%0d: got %h expected %h", i, r, ack_rdata[i][f], exp_rd[i][f]);
        end
        if (s >= 0) begin
          if (!wev[s]) exp_rd[i][s] = io_out;
          n_tests++;
          if (ack_cnt[i][s] != 1 || ack_cyc[i][s] != t0 + 2 * wc(i) + 4 || ack_rdata[i][s] !== exp_rd[i][s]) begin
            n_fail++; $display("FAIL rr_second inst%0d r%0d m%0d: got cnt=%0d at %0d data=%h expected 1 at %0d data=%h", i, r, s, ack_cnt[i][s], ack_cyc[i][s] - t0, ack_rdata[i][s], 2 * wc(i) + 4, exp_rd[i][s]);
          end
          mlast[i] = s;
        end else begin
          n_tests++;
          if (ack_cnt[i][1-f] != 0) begin
            n_fail++; $display("FAIL rr_single inst%0d r%0d: got %0d acks on idle master expected 0", i, r, ack_cnt[i][1-f]);
          end
          mlast[i] = f;
        end
      end
    end
  endtask

  task automatic test_busy_ignore();
    int t0;
    clear_obs();
    io_out = 16'($urandom); chk_en = 1'b1; exp_en_addr = 16'h8044; exp_en_wdata = '0;
    m0_we = 1'b0; m0_addr = 16'h8044; m0_wdata = '0; m0_req = 1'b1;
    step(); t0 = cyc;
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (busy0_v[i] !== 1'b1) begin
        n_fail++; $display("FAIL busy_set inst%0d: got %b expected 1", i, busy0_v[i]);
      end
    end
    m0_we = 1'b1; m0_addr = 16'h8066; m0_wdata = 16'h5A5A;
    step(); m0_req = 1'b0;
    step(); m0_req = 1'b1;
    step(); m0_req = 1'b0;
    repeat (10) step();
    for (int i = 0; i < 2; i++) begin
      exp_rd[i][0] = io_out;
      n_tests++;
      if (ack_cnt[i][0] != 1 || ack_cyc[i][0] != t0 + wc(i) + 2 || ack_rdata[i][0] !== exp_rd[i][0]) begin
        n_fail++; $display("FAIL busy_ack inst%0d: got cnt=%0d at %0d data=%h expected 1 at %0d data=%h", i, ack_cnt[i][0], ack_cyc[i][0] - t0, ack_rdata[i][0], wc(i) + 2, exp_rd[i][0]);
      end
      n_tests++;
      if (rd_cnt[i] != wc(i) || wr_cnt[i] != 0 || en_bad[i] != 0 || busy0_v[i] !== 1'b0) begin
        n_fail++; $display("FAIL busy_bus inst%0d: got rd=%0d wr=%0d bad=%0d busy=%b expected rd=%0d wr=0 bad=0 busy=0", i, rd_cnt[i], wr_cnt[i], en_bad[i], busy0_v[i], wc(i));
      end
      mlast[i] = 0;
    end
  endtask

  task automatic test_reset_abort();
    int t0;
    clear_obs();
    m1_we = 1'b1; m1_addr = 16'h8020; m1_wdata = 16'($urandom); m1_req = 1'b1;
    step(); m1_req = 1'b0;
    step(); step();
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (wen_v[i] !== 1'b1) begin
        n_fail++; $display("FAIL abort_pre inst%0d: got write_en=%b expected 1", i, wen_v[i]);
      end
    end
    do_reset(1);
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if ({wen_v[i], ren_v[i], busy1_v[i], ack1_v[i], busy0_v[i]} !== 5'b0) begin
        n_fail++; $display("FAIL abort_reset inst%0d: got we=%b re=%b busy1=%b ack1=%b busy0=%b expected 0", i, wen_v[i], ren_v[i], busy1_v[i], ack1_v[i], busy0_v[i]);
      end
    end
    clear_obs();
    repeat (6) step();
    io_out = 16'($urandom);
    m1_we = 1'b0; m1_addr = 16'h8030; m1_req = 1'b1;
    step(); t0 = cyc; m1_req = 1'b0;
    repeat (10) step();
    for (int i = 0; i < 2; i++) begin
      exp_rd[i][1] = io_out;
      n_tests++;
      if (ack_cnt[i][1] != 1 || ack_cyc[i][1] != t0 + wc(i) + 2 || ack_rdata[i][1] !== exp_rd[i][1] || ack_cnt[i][0] != 0) begin
        n_fail++; $display("FAIL abort_fresh inst%0d: got cnt=%0d at %0d data=%h expected 1 at %0d data=%h", i, ack_cnt[i][1], ack_cyc[i][1] - t0, ack_rdata[i][1], wc(i) + 2, exp_rd[i][1]);
      end
      mlast[i] = 1;
    end
  endtask

  initial begin
    rst_n = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
    clear_obs();
    test_reset();
    test_read();
    test_write();
    test_err();
    test_random();
    test_contention();
    test_busy_ignore();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
`default_nettype wire
